// File: rtl/key_event_scheduler.sv
// Turns the 4-slot HID keycode word into per-frame press/auto-repeat events for two players,
// queued as pending bits and round-robin arbitrated onto a single valid/ready event slot.
module key_event_scheduler #(
    parameter int REPEAT_DELAY = 30,
    parameter int REPEAT_RATE  = 6,
    parameter int CNT_W        = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic [31:0] keycode,
    input  logic        evt_ready,
    input  logic        clr_drop,
    output logic        evt_valid,
    output logic        evt_player,
    output logic [2:0]  evt_code,
    output logic        evt_repeat,
    output logic [9:0]  held,
    output logic        drop_sticky
);

    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Bit i of held/pending: player = i/5, code = i%5 (0 U, 1 L, 2 D, 3 R, 4 ACT)
    function automatic logic [7:0] key_code(input int idx);
        case (idx)
            0:       return 8'h1A;
            1:       return 8'h04;
            2:       return 8'h16;
            3:       return 8'h07;
            4:       return 8'h08;
            5:       return 8'h52;
            6:       return 8'h50;
            7:       return 8'h51;
            8:       return 8'h4F;
            default: return 8'h2C;
        endcase
    endfunction

    function automatic logic byte_hit(input logic [31:0] kc, input logic [7:0] code);
        return (kc[7:0] == code) || (kc[15:8] == code) ||
               (kc[23:16] == code) || (kc[31:24] == code);
    endfunction

    // Fixed priority within one player: ACT > U > L > D > R
    function automatic logic [2:0] pick(input logic [4:0] p);
        if (p[4])      return 3'd4;
        else if (p[0]) return 3'd0;
        else if (p[1]) return 3'd1;
        else if (p[2]) return 3'd2;
        else           return 3'd3;
    endfunction

    logic [9:0]       new_held;
    logic [9:0]       pending_q, pending_d;
    logic [9:0]       rep_q, rep_d;
    logic [9:0]       req, req_rep;
    logic [CNT_W-1:0] cnt_q [10];
    logic [CNT_W-1:0] cnt_d [10];
    logic             last_grant_q;

    logic             p0_any, p1_any, any_pend;
    logic             grant_p;
    logic [2:0]       grant_code;
    logic [3:0]       grant_idx;
    logic             load, take, drop;
    logic [9:0]       clr_mask;

    // Frame sampling: press detection and auto-repeat counters
    always_comb begin
        new_held = '0;
        req      = '0;
        req_rep  = '0;
        for (int i = 0; i < 10; i++) begin
            new_held[i] = byte_hit(keycode, key_code(i));
            cnt_d[i]    = cnt_q[i];
            if (frame_tick) begin
                if (new_held[i] && !held[i]) begin
                    req[i]   = 1'b1;
                    cnt_d[i] = (i == 4 || i == 9) ? '0 : DELAY_C;
                end else if (new_held[i]) begin
                    if ((i != 4) && (i != 9) && (cnt_q[i] == ONE_C)) begin
                        req[i]     = 1'b1;
                        req_rep[i] = 1'b1;
                        cnt_d[i]   = RATE_C;
                    end else if (cnt_q[i] > ONE_C) begin
                        cnt_d[i] = cnt_q[i] - ONE_C;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // Arbitration and slot load; a request on the bit being granted re-arms it without a drop
    always_comb begin
        p0_any     = |pending_q[4:0];
        p1_any     = |pending_q[9:5];
        any_pend   = p0_any | p1_any;
        grant_p    = (p0_any && p1_any) ? ~last_grant_q : p1_any;
        grant_code = pick(grant_p ? pending_q[9:5] : pending_q[4:0]);
        grant_idx  = grant_p ? (4'(grant_code) + 4'd5) : 4'(grant_code);
        load       = !evt_valid || evt_ready;
        take       = load && any_pend;
        clr_mask   = take ? (10'b1 << grant_idx) : '0;
        pending_d  = (pending_q & ~clr_mask) | req;
        drop       = |(req & pending_q & ~clr_mask);
        rep_d      = (rep_q & ~req) | (req_rep & req);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            held         <= '0;
            pending_q    <= '0;
            rep_q        <= '0;
            for (int i = 0; i < 10; i++) cnt_q[i] <= '0;
            last_grant_q <= 1'b1;
            evt_valid    <= 1'b0;
            evt_player   <= 1'b0;
            evt_code     <= 3'd0;
            evt_repeat   <= 1'b0;
            drop_sticky  <= 1'b0;
        end else begin
            if (frame_tick) held <= new_held;
            pending_q <= pending_d;
            rep_q     <= rep_d;
            for (int i = 0; i < 10; i++) cnt_q[i] <= cnt_d[i];
            if (take) begin
                evt_valid    <= 1'b1;
                evt_player   <= grant_p;
                evt_code     <= grant_code;
                evt_repeat   <= rep_q[grant_idx];
                last_grant_q <= grant_p;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (drop)          drop_sticky <= 1'b1;
            else if (clr_drop) drop_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Directed bench for key_event_scheduler: press/repeat timing, arbitration order,
// drop handling, slot stability and asynchronous reset.
module tb_key_event_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_tick;
    logic [31:0] keycode;
    logic        evt_ready;
    logic        clr_drop;
    logic        evt_valid;
    logic        evt_player;
    logic [2:0]  evt_code;
    logic        evt_repeat;
    logic [9:0]  held;
    logic        drop_sticky;

    key_event_scheduler #(.REPEAT_DELAY(30), .REPEAT_RATE(6), .CNT_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
        .evt_ready(evt_ready), .clr_drop(clr_drop), .evt_valid(evt_valid),
        .evt_player(evt_player), .evt_code(evt_code), .evt_repeat(evt_repeat),
        .held(held), .drop_sticky(drop_sticky)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       player;
        logic [2:0] code;
        logic       rep;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Accepted events are logged mid-cycle, before the edge that completes the handshake
    always @(negedge Clk) begin
        if (Reset_n && evt_valid && evt_ready)
            q.push_back('{player: evt_player, code: evt_code, rep: evt_repeat});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Code 7 never occurs, so a missing entry can never match an expected event
    task automatic check_ev(input string tag, input int idx, input logic p,
                            input logic [2:0] c, input logic r);
        logic [4:0] got;
        got = (idx < q.size()) ? q[idx] : 5'b1_111_1;
        check(tag, 32'(got), 32'({p, c, r}));
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Tick is high for one cycle; returns early in the cycle after the sampling edge
    task automatic frame(input logic [31:0] kc);
        step();
        keycode    = kc;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        repeat (3) step();
        Reset_n = 1'b1;
    endtask

    int ev_tick [$];
    int ev_rep  [$];
    int ev_code [$];

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        keycode    = '0;
        evt_ready  = 1'b0;
        clr_drop   = 1'b0;
        do_reset();

        check("reset_outputs", {evt_valid, evt_player, evt_code, evt_repeat, held, drop_sticky}, 0);

        // Single W press, minimal latency
        evt_ready = 1'b1;
        frame(32'h0000_001A);
        check("w_held", held, 10'h001);
        check("w_not_yet_valid", evt_valid, 0);
        step();
        check("w_event", {evt_valid, evt_player, evt_code, evt_repeat}, 6'b1_0_000_0);
        step();
        check("w_slot_empty", evt_valid, 0);
        frame(32'h0);

        // Dual press from reset: player 0 first, then alternation
        do_reset();
        evt_ready = 1'b1;
        frame(32'h0000_521A);
        check("dual_held", held, 10'h021);
        step();
        check("dual_first", {evt_valid, evt_player, evt_code, evt_repeat}, 6'b1_0_000_0);
        step();
        check("dual_second", {evt_valid, evt_player, evt_code, evt_repeat}, 6'b1_1_000_0);
        step();
        check("dual_empty", evt_valid, 0);
        frame(32'h0);
        q.delete();
        frame(32'h0000_001A);
        repeat (3) step();
        frame(32'h0);
        frame(32'h0000_521A);
        repeat (4) step();
        frame(32'h0);
        check("alt_count", q.size(), 3);
        check_ev("alt_w_alone", 0, 1'b0, 3'd0, 1'b0);
        check_ev("alt_p1_first", 1, 1'b1, 3'd0, 1'b0);
        check_ev("alt_p0_second", 2, 1'b0, 3'd0, 1'b0);

        // D held for 40 frames: press at 0, repeats at 30 and 36
        q.delete();
        for (int k = 0; k < 40; k++) begin
            frame(32'h0000_0016);
            repeat (3) step();
            while (q.size() > 0) begin
                ev_t e;
                e = q.pop_front();
                ev_tick.push_back(k);
                ev_rep.push_back(int'(e.rep));
                ev_code.push_back(int'({e.player, e.code}));
            end
        end
        frame(32'h0);
        check("rpt_count", ev_tick.size(), 3);
        for (int j = 0; j < 3; j++) begin
            int exp_tick;
            exp_tick = (j == 0) ? 0 : (j == 1) ? 30 : 36;
            check($sformatf("rpt_tick%0d", j), (j < ev_tick.size()) ? ev_tick[j] : -1, exp_tick);
            check($sformatf("rpt_flag%0d", j), (j < ev_rep.size()) ? ev_rep[j] : -1, (j == 0) ? 0 : 1);
            check($sformatf("rpt_code%0d", j), (j < ev_code.size()) ? ev_code[j] : -1, 2);
        end

        // E held: action keys never repeat
        q.delete();
        for (int k = 0; k < 35; k++) frame(32'h0000_0008);
        repeat (3) step();
        frame(32'h0);
        check("act_no_repeat_count", q.size(), 1);
        check_ev("act_press", 0, 1'b0, 3'd4, 1'b0);

        // Drop: slot held by E, A pending, A re-pressed while still pending
        q.delete();
        evt_ready = 1'b0;
        frame(32'h0000_0008);
        frame(32'h0000_0004);
        frame(32'h0);
        check("drop_not_yet", drop_sticky, 0);
        frame(32'h0000_0004);
        check("drop_set", drop_sticky, 1);
        check("drop_slot_stable", {evt_valid, evt_player, evt_code}, 5'b1_0_100);
        evt_ready = 1'b1;
        repeat (4) step();
        check("drop_count", q.size(), 2);
        check_ev("drop_ev0", 0, 1'b0, 3'd4, 1'b0);
        check_ev("drop_ev1", 1, 1'b0, 3'd1, 1'b0);
        clr_drop = 1'b1;
        step();
        clr_drop = 1'b0;
        check("drop_cleared", drop_sticky, 0);
        frame(32'h0);

        // E+S+W together: ACT, UP, DOWN, slot stable under backpressure
        q.delete();
        evt_ready = 1'b0;
        frame(32'h0008_161A);
        step();
        check("multi_first", {evt_valid, evt_player, evt_code, evt_repeat}, 6'b1_0_100_0);
        repeat (5) step();
        check("multi_stable", {evt_valid, evt_player, evt_code, evt_repeat}, 6'b1_0_100_0);
        evt_ready = 1'b1;
        repeat (4) step();
        check("multi_count", q.size(), 3);
        check_ev("multi_ev0", 0, 1'b0, 3'd4, 1'b0);
        check_ev("multi_ev1", 1, 1'b0, 3'd0, 1'b0);
        check_ev("multi_ev2", 2, 1'b0, 3'd2, 1'b0);
        frame(32'h0);

        // Async reset with a full slot and three pending keys
        q.delete();
        evt_ready = 1'b0;
        frame(32'h0816_1A04);
        repeat (3) step();
        check("pre_reset_valid", evt_valid, 1);
        keycode = '0;
        Reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {evt_valid, evt_player, evt_code, evt_repeat, held, drop_sticky}, 0);
        repeat (2) step();
        Reset_n   = 1'b1;
        evt_ready = 1'b1;
        repeat (10) step();
        check("no_stale_events", q.size(), 0);
        check("no_stale_valid", evt_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
